// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the PC-next unit
package pc_pkg;

    // Encoding order equals priority order: a larger value wins.
    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_MRET   = 3'd3,
        SRC_TRAP   = 3'd4
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    localparam int PC_INC  = 4;
    localparam int NUM_SRC = 5;

endpackage

// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - redirect inputs and PC outputs of the fetch PC unit
interface pc_next_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            branch_take_i;
    logic [XLEN-1:0] branch_target_i;
    logic            jump_i;
    logic [XLEN-1:0] jump_target_i;
    logic            mret_i;
    logic [XLEN-1:0] epc_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_vector_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;

    // Pipeline / trap logic side: drives redirects, observes the PC.
    modport master (
        output stall_i, branch_take_i, branch_target_i, jump_i, jump_target_i,
        output mret_i, epc_i, trap_i, trap_vector_i,
        input  pc_o, pc_plus_o, pc_valid_o, misalign_o, misalign_addr_o
    );

    // PC unit side.
    modport slave (
        input  stall_i, branch_take_i, branch_target_i, jump_i, jump_target_i,
        input  mret_i, epc_i, trap_i, trap_vector_i,
        output pc_o, pc_plus_o, pc_valid_o, misalign_o, misalign_addr_o
    );
endinterface

// File: rtl/pc_src_arbiter.sv
// rtl/pc_src_arbiter.sv - fixed-priority selection of the next-PC source
module pc_src_arbiter
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [XLEN-1:0]    tgt [NUM_SRC],
    output pc_src_e            src,
    output logic [XLEN-1:0]    target
);

    // Scan upward so the highest-numbered (highest-priority) request wins.
    always_comb begin
        src    = SRC_SEQ;
        target = tgt[0];
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i]) begin
                src    = pc_src_e'(3'(i));
                target = tgt[i];
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - fetch-stage PC register with stall-safe redirects
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR   = '0,
    parameter int              IALIGN         = 4,
    parameter int              MISALIGN_CHECK = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_next_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] ALIGN_LSB = XLEN'(IALIGN - 1);

    pc_state_e         state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, pc_plus;
    pc_src_e           pend_src_q, pend_src_d;
    logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   mis_addr_q, mis_addr_d;

    logic [NUM_SRC-1:0] live_req, merge_req;
    logic [XLEN-1:0]    live_tgt  [NUM_SRC];
    logic [XLEN-1:0]    merge_tgt [NUM_SRC];
    pc_src_e            live_src, merge_src;
    logic [XLEN-1:0]    live_target, merge_target;

    logic               commit_en;
    pc_src_e            commit_src;
    logic [XLEN-1:0]    commit_tgt;
    logic               commit_bad;

    assign pc_plus  = pc_q + XLEN'(PC_INC);
    assign live_req = {bus.trap_i, bus.mret_i, bus.jump_i, bus.branch_take_i, 1'b1};

    // Candidate targets; trap and mret addresses are forced to the fetch alignment.
    always_comb begin
        live_tgt[SRC_SEQ]    = pc_plus;
        live_tgt[SRC_BRANCH] = bus.branch_target_i;
        live_tgt[SRC_JUMP]   = bus.jump_target_i;
        live_tgt[SRC_MRET]   = bus.epc_i & ~ALIGN_LSB;
        live_tgt[SRC_TRAP]   = bus.trap_vector_i & ~ALIGN_LSB;
    end

    // Pending redirect injected into its own slot; taking the slot gives it the tie.
    always_comb begin
        merge_req = live_req | (NUM_SRC'(1) << pend_src_q);
        for (int i = 0; i < NUM_SRC; i++) begin
            merge_tgt[i] = (i == int'(pend_src_q)) ? pend_tgt_q : live_tgt[i];
        end
    end

    pc_src_arbiter #(.XLEN(XLEN)) u_live_arb (
        .req    (live_req),
        .tgt    (live_tgt),
        .src    (live_src),
        .target (live_target)
    );

    pc_src_arbiter #(.XLEN(XLEN)) u_merge_arb (
        .req    (merge_req),
        .tgt    (merge_tgt),
        .src    (merge_src),
        .target (merge_target)
    );

    // FSM next state: decide what commits to the PC and what is parked during stalls.
    always_comb begin
        state_d    = state_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        commit_en  = 1'b0;
        commit_src = SRC_SEQ;
        commit_tgt = pc_plus;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (!bus.stall_i) begin
                    commit_en  = 1'b1;
                    commit_src = live_src;
                    commit_tgt = live_target;
                end else if (live_src != SRC_SEQ) begin
                    pend_src_d = live_src;
                    pend_tgt_d = live_target;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (bus.stall_i) begin
                    if (live_src != SRC_SEQ && live_src >= pend_src_q) begin
                        pend_src_d = live_src;
                        pend_tgt_d = live_target;
                    end
                end else begin
                    commit_en  = 1'b1;
                    commit_src = merge_src;
                    commit_tgt = merge_target;
                    pend_src_d = SRC_SEQ;
                    pend_tgt_d = '0;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // A misaligned jump/branch is rejected: PC stays on the faulting instruction.
    always_comb begin
        commit_bad = (MISALIGN_CHECK != 0) && commit_en &&
                     (commit_src == SRC_JUMP || commit_src == SRC_BRANCH) &&
                     ((commit_tgt & ALIGN_LSB) != '0);
        pc_d       = pc_q;
        mis_d      = 1'b0;
        mis_addr_d = mis_addr_q;
        if (commit_bad) begin
            mis_d      = 1'b1;
            mis_addr_d = commit_tgt;
        end else if (commit_en) begin
            pc_d = commit_tgt;
        end
    end

    // State, PC, pending redirect and misalign report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_src_q <= SRC_SEQ;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.pc_plus_o       = pc_plus;
    assign bus.pc_valid_o      = (state_q != BOOT);
    assign bus.misalign_o      = mis_q;
    assign bus.misalign_addr_o = mis_addr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit
module tb_pc_next_unit;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic        mret;
        logic [31:0] epc;
        logic        trap;
        logic [31:0] tvec;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[$];
    exp_t sbq[$];

    always #5 clk = ~clk;

    pc_next_unit_if #(.XLEN(32)) bus4 ();
    pc_next_unit_if #(.XLEN(32)) bus2 ();

    pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .MISALIGN_CHECK(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    pc_next_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .MISALIGN_CHECK(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt,
                                input logic m, input logic [31:0] ep,
                                input logic t, input logic [31:0] tv,
                                input logic [31:0] epc_exp, input logic emis,
                                input logic [31:0] emaddr);
        vec_t v;
        v.stall = s;  v.br = b;   v.brt = bt;  v.jmp = j;  v.jmpt = jt;
        v.mret = m;   v.epc = ep; v.trap = t;  v.tvec = tv;
        v.e_pc = epc_exp; v.e_mis = emis; v.e_maddr = emaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        bus4.stall_i = v.stall; bus4.branch_take_i = v.br; bus4.branch_target_i = v.brt;
        bus4.jump_i = v.jmp; bus4.jump_target_i = v.jmpt; bus4.mret_i = v.mret;
        bus4.epc_i = v.epc; bus4.trap_i = v.trap; bus4.trap_vector_i = v.tvec;
        bus2.stall_i = v.stall; bus2.branch_take_i = v.br; bus2.branch_target_i = v.brt;
        bus2.jump_i = v.jmp; bus2.jump_target_i = v.jmpt; bus2.mret_i = v.mret;
        bus2.epc_i = v.epc; bus2.trap_i = v.trap; bus2.trap_vector_i = v.tvec;
    endtask

    task automatic run(input vec_t v, input string tag);
        exp_t e;
        apply(v);
        sbq.push_back('{v.e_pc, v.e_mis, v.e_maddr});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "_pc"}, bus4.pc_o, e.pc);
        chk({tag, "_pc_plus"}, bus4.pc_plus_o, e.pc + 32'd4);
        chk({tag, "_valid"}, 32'(bus4.pc_valid_o), 32'd1);
        chk({tag, "_mis"}, 32'(bus4.misalign_o), 32'(e.mis));
        chk({tag, "_maddr"}, bus4.misalign_addr_o, e.maddr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk);
        #1;
        chk("rst_pc", bus4.pc_o, 32'h0);
        chk("rst_valid", 32'(bus4.pc_valid_o), 32'd0);
        chk("rst_mis", 32'(bus4.misalign_o), 32'd0);
        chk("rst_maddr", bus4.misalign_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //          stall br brt         jmp jmpt        mret epc         trap tvec       pc            mis maddr
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h300,    0, 32'h0,     0, 32'h0,   32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h4,        0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h8,        0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'hC,        0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h100,    0, 32'h0,     0, 32'h0,   32'h100,      0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h300,    0, 32'h0,     1, 32'h1C0, 32'h1C0,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h100,    0, 32'h0,     0, 32'h0,   32'h100,      0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h200, 1, 32'h300,    0, 32'h0,     0, 32'h0,   32'h300,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      1, 32'h1003,  0, 32'h0,   32'h1000,     0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     1, 32'h1C3, 32'h1C0,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40,     0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h80,  0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h80,       0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h40,     0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h80,  0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,      0, 32'h0,     1, 32'h1C0, 32'h40,       0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h40,       0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h1C0,      0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h600,    0, 32'h0,     0, 32'h0,   32'h1C0,      0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h700, 0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h1C0,      0, 32'h0));
        vecs.push_back(mk(0, 1, 32'h800, 0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h600,      0, 32'h0));
        vecs.push_back(mk(1, 1, 32'h900, 0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h600,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'hA00,    0, 32'h0,     0, 32'h0,   32'hA00,      0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'hB00,    0, 32'h0,     0, 32'h0,   32'hA00,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'hC00,    0, 32'h0,     0, 32'h0,   32'hB00,      0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h10,     0, 32'h0,     0, 32'h0,   32'h10,       0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h22,     0, 32'h0,     0, 32'h0,   32'h10,       1, 32'h22));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h14,       0, 32'h22));
        vecs.push_back(mk(0, 1, 32'h31,  0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h14,       1, 32'h31));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h22,     0, 32'h0,     1, 32'h100, 32'h100,      0, 32'h31));
        vecs.push_back(mk(1, 0, 32'h0,   1, 32'h46,     0, 32'h0,     0, 32'h0,   32'h100,      0, 32'h31));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h100,      1, 32'h46));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'hFFFF_FFFC, 0, 32'h0,  0, 32'h0,   32'hFFFF_FFFC, 0, 32'h46));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h0,        0, 32'h46));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,      0, 32'h0,     0, 32'h0,   32'h4,        0, 32'h46));

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i], $sformatf("v%0d", i));
        end

        // Same misaligned target on a 2-byte-aligned unit is accepted.
        do_reset();
        run(mk(0,0,0, 0,0,     0,0,       0,0, 32'h0,    0, 32'h0),  "a_boot");
        run(mk(0,0,0, 1,32'h10,0,0,       0,0, 32'h10,   0, 32'h0),  "a_j10");
        run(mk(0,0,0, 1,32'h22,0,0,       0,0, 32'h10,   1, 32'h22), "a_j22");
        chk("ia2_pc", bus2.pc_o, 32'h22);
        chk("ia2_mis", 32'(bus2.misalign_o), 32'd0);
        chk("ia2_maddr", bus2.misalign_addr_o, 32'h0);
        run(mk(0,0,0, 0,0,     1,32'h1003,0,0, 32'h1000, 0, 32'h22), "a_mret");
        chk("ia2_mret_pc", bus2.pc_o, 32'h1002);

        // Reset between edges while a jump is pending in HOLD.
        do_reset();
        run(mk(0,0,0, 0,0,      0,0, 0,0, 32'h0,   0, 32'h0), "r_boot");
        run(mk(0,0,0, 1,32'h100,0,0, 0,0, 32'h100, 0, 32'h0), "r_j100");
        run(mk(1,0,0, 1,32'h500,0,0, 0,0, 32'h100, 0, 32'h0), "r_hold");
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_pc", bus4.pc_o, 32'h0);
        chk("r_async_valid", 32'(bus4.pc_valid_o), 32'd0);
        chk("r_async_mis", 32'(bus4.misalign_o), 32'd0);
        apply(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0));
        @(posedge clk);
        #1;
        chk("r_held_valid", 32'(bus4.pc_valid_o), 32'd0);
        rst_n = 1'b1;
        run(mk(0,0,0, 0,0, 0,0, 0,0, 32'h0, 0, 32'h0), "r_reboot");
        run(mk(0,0,0, 0,0, 0,0, 0,0, 32'h4, 0, 32'h0), "r_seq4");
        run(mk(0,0,0, 0,0, 0,0, 0,0, 32'h8, 0, 32'h0), "r_seq8");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
